key_event_arbiter: RTL
======================

# key_event_arbiter

Collects one-cycle release pulses from the multi-key debouncer and serialises them into an ordered event stream for the downstream menu/setpoint logic. Simultaneous or back-to-back key events are held per key, granted one per cycle by a round-robin arbiter, and buffered in a small show-ahead FIFO. The consumer drains the FIFO through a valid/ready handshake. Lost events raise a sticky overflow flag.

## Interface
- KEY_NUM, 4: number of keys; pulse vector width; ≥2.
- FIFO_DEPTH, 4: event FIFO entries; power of 2, ≥2.
- CODE_W, $clog2(KEY_NUM): event code width (derived).
- LVL_W, $clog2(FIFO_DEPTH)+1: level width (derived).
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- key_pulse  in  KEY_NUM  debounced one-cycle pulses, bit i = key i released; any number of bits per cycle.
- evt_valid  out  1  FIFO non-empty; evt_code valid.
- evt_ready  in  1  consumer accepts head event when evt_valid=1.
- evt_code  out  CODE_W  index of key at FIFO head; 0 when empty.
- evt_level  out  LVL_W  number of FIFO entries, 0..FIFO_DEPTH.
- overflow  out  1  sticky; an event was lost.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- Pending register pend[KEY_NUM]: bit i set at the clock edge sampling key_pulse[i]=1; cleared at the edge where key i is granted.
- Pulse on key i in the same cycle key i is granted: pend[i] stays 1 (new event, nothing lost).
- Pulse on key i while pend[i]=1 and key i not granted that cycle: merged, pend[i] stays 1, overflow set.
- Arbiter: combinational, round-robin over pend, pointer ptr (reset 0). Search order ptr, ptr+1, ... mod KEY_NUM; first set bit wins.
- Grant allowed when pend≠0 and (FIFO not full, or FIFO full and pop this cycle).
- On grant of key g: push g into FIFO, clear pend[g], ptr ← (g+1) mod KEY_NUM. No grant: ptr unchanged.
- At most one grant and one push per cycle.
- FIFO: show-ahead; pop when evt_valid && evt_ready. Read/write pointers LVL_W bits, wrap modulo 2·FIFO_DEPTH; full = MSBs differ, lower bits equal.
- Simultaneous push and pop: allowed in every state incl. full; level unchanged.
- evt_ready while empty: ignored, no pointer change.
- Overflow only from merge case; FIFO-full never loses events (pend holds them).
- ovf_clr=1: overflow ← 0, unless a merge loss occurs the same cycle (set wins).

## Timing
- Reset values: pend=0, ptr=0, FIFO empty, evt_valid=0, evt_code=0, evt_level=0, overflow=0.
- Reset asserted mid-operation: all state returns to reset values immediately; buffered and pending events discarded.
- Latency, idle block: key_pulse high in cycle t → pend set after edge t → grant + push at edge t+1 → evt_valid=1, evt_code=key in cycle t+2.
- Throughput: one event per cycle in and out when consumer holds evt_ready=1.
- evt_valid, evt_code, evt_level, overflow driven from registers / register-only decode; no combinational path from key_pulse or evt_ready to any output.
- evt_level updates the cycle after push/pop edge, consistent with evt_valid.

## Test plan
- Single pulse key 2, evt_ready=1: evt_valid high exactly cycle t+2 with evt_code=2 for one cycle, evt_level 1→0, overflow=0.
- key_pulse=4'b1111 in one cycle, evt_ready=1, ptr=0: codes 0,1,2,3 on consecutive cycles; next simultaneous burst 4'b0011 after ptr=0 yields 0,1; burst 4'b0101 after last grant 0 yields 2 then 0.
- evt_ready=0, pulses on keys 0,1,2,3,0 then 1 spaced 3 cycles: FIFO fills to evt_level=4 (0,1,2,3); key0 and key1 remain pending, overflow=0; raise evt_ready → stream 0,1,2,3,0,1, level never exceeds 4.
- FIFO full, evt_ready=1 with pend nonzero: push and pop same cycle, evt_level stays 4 until pend drains.
- Second pulse on key 3 while pend[3]=1 and FIFO full: overflow=1, only one key-3 event delivered; ovf_clr pulse → overflow=0; ovf_clr coinciding with new merge → overflow stays 1.
- rst_n low for 1 cycle with 3 entries buffered and 2 keys pending: all outputs return to reset values, no events emitted afterwards.

Source files
------------

// File: rtl/key_event_arbiter.sv
// Serialises one-cycle key release pulses into an ordered event stream:
// per-key pending bits, a round-robin arbiter and a show-ahead event FIFO.
module key_event_arbiter #(
    parameter int KEY_NUM    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CODE_W     = $clog2(KEY_NUM),
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] i_key_pulse,
    output logic               o_evt_valid,
    input  logic               i_evt_ready,
    output logic [CODE_W-1:0]  o_evt_code,
    output logic [LVL_W-1:0]   o_evt_level,
    output logic               o_overflow,
    input  logic               i_ovf_clr
);

    localparam int                IDX_W    = LVL_W - 1;
    localparam int                SUM_W    = CODE_W + 1;
    localparam logic [CODE_W-1:0] LAST_KEY = CODE_W'(KEY_NUM - 1);
    localparam logic [SUM_W-1:0]  KEY_MOD  = SUM_W'(KEY_NUM);

    logic [KEY_NUM-1:0] r_pend;
    logic [CODE_W-1:0]  r_ptr;
    logic [CODE_W-1:0]  r_mem [FIFO_DEPTH];
    logic [LVL_W-1:0]   r_wptr;
    logic [LVL_W-1:0]   r_rptr;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_grant;
    logic               w_found;
    logic [KEY_NUM-1:0] w_rot;
    logic [SUM_W-1:0]   w_sum;
    logic [CODE_W-1:0]  w_gnt_idx;
    logic [CODE_W-1:0]  w_next_ptr;
    logic [KEY_NUM-1:0] w_gnt_onehot;
    logic               w_merge_loss;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[LVL_W-1] != r_rptr[LVL_W-1]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
    assign w_pop   = !w_empty && i_evt_ready;

    // Rotate pend so the pointer position lands on bit 0, pick the lowest set
    // bit, then map the offset back to an absolute key index.
    always_comb begin
        w_rot   = KEY_NUM'({r_pend, r_pend} >> r_ptr);
        w_found = 1'b0;
        w_sum   = {1'b0, r_ptr};
        for (int off = 0; off < KEY_NUM; off++) begin
            if (!w_found && w_rot[off]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + SUM_W'(off);
            end
        end
        if (w_sum >= KEY_MOD) begin
            w_sum = w_sum - KEY_MOD;
        end
        w_gnt_idx = w_sum[CODE_W-1:0];
    end

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign w_grant      = w_found && (!w_full || w_pop);
    assign w_next_ptr   = (w_gnt_idx == LAST_KEY) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_onehot = w_grant ? (KEY_NUM'(1) << w_gnt_idx) : '0;
    assign w_merge_loss = |(i_key_pulse & r_pend & ~w_gnt_onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ptr  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gnt_onehot) | i_key_pulse;
            if (w_grant) begin
                r_ptr <= w_next_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_merge_loss) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_mem[r_wptr[IDX_W-1:0]] <= w_gnt_idx;
                r_wptr                   <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_evt_valid = !w_empty;
    assign o_evt_code  = w_empty ? '0 : r_mem[r_rptr[IDX_W-1:0]];
    assign o_evt_level = r_wptr - r_rptr;
    assign o_overflow  = r_overflow;

endmodule
